// File: rtl/ntt_pkg.sv
// Shared types and default sizing for the NTT pipeline controller.
package ntt_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} ntt_ctrl_state_t;
    typedef enum logic {NTT_FWD, NTT_INV} ntt_mode_t;

    localparam int ADDR_W = 8;
    localparam int HALF_N = 1 << (ADDR_W - 1);

endpackage

// File: rtl/ntt_pipe_control_if.sv
// Controller-to-datapath bundle; the optional perf counters appear only when NTT_CTRL_PERF_EN is defined.
interface ntt_pipe_control_if #(
    parameter int LOG_N = 8
);
    logic             start;
    logic             inv;
    logic             clear;
    logic             busy;
    logic             done;
    logic [LOG_N-1:0] stage;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_a;
    logic [LOG_N-1:0] rd_addr_b;
    logic [LOG_N-2:0] tw_addr;
    logic             bf_valid;
    logic             bf_inv;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;
`ifdef NTT_CTRL_PERF_EN
    logic [31:0]      cycle_cnt;
    logic [15:0]      run_cnt;
`endif

    modport master (
        input  start, inv, clear,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_valid, bf_inv, wr_en, wr_addr_a, wr_addr_b
`ifdef NTT_CTRL_PERF_EN
        , output cycle_cnt, run_cnt
`endif
    );

    modport slave (
        output start, inv, clear,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_valid, bf_inv, wr_en, wr_addr_a, wr_addr_b
`ifdef NTT_CTRL_PERF_EN
        , input cycle_cnt, run_cnt
`endif
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly/twiddle address generator, zero latency, no backpressure.
// log2(h) is stage for DIT and LOG_N-1-stage for DIF, so division/modulo reduce to shift and mask.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LOG_N = ADDR_W
) (
    input  logic [LOG_N-1:0] stage,
    input  logic [LOG_N-2:0] bf,
    input  ntt_mode_t        mode,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [LOG_N-2:0] tw_addr
);
    localparam int TW_W = LOG_N - 1;

    logic [LOG_N-1:0] sh;
    logic [LOG_N-1:0] bf_w;
    logic [LOG_N-1:0] lo;
    logic [LOG_N-1:0] hi;

    always_comb begin
        sh      = (mode == NTT_INV) ? LOG_N'(LOG_N - 1) - stage : stage;
        bf_w    = {1'b0, bf};
        lo      = bf_w & ((LOG_N'(1) << sh) - LOG_N'(1));
        hi      = (bf_w >> sh) << (sh + LOG_N'(1));
        addr_a  = hi | lo;
        addr_b  = addr_a + (LOG_N'(1) << sh);
        tw_addr = (mode == NTT_INV) ? TW_W'(lo << stage)
                                    : TW_W'(lo << (LOG_N'(LOG_N - 1) - stage));
    end

endmodule

// File: rtl/ntt_pipe_control.sv
// In-place radix-2 NTT/INTT sequencer: one butterfly/cycle, writes PIPE cycles after reads, PIPE-cycle drain per stage.
// No backpressure (clear aborts); NTT_CTRL_PERF_EN adds busy-cycle and run counters.
module ntt_pipe_control
    import ntt_pkg::*;
#(
    parameter int LOG_N      = ADDR_W,
    parameter int RD_LATENCY = 1,
    parameter int BF_LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    ntt_pipe_control_if.master bus
);
    localparam int PIPE = RD_LATENCY + BF_LATENCY;
    localparam int CW   = $clog2(PIPE + 1);

    ntt_ctrl_state_t  state, state_n;
    ntt_mode_t        mode, mode_n;
    logic [LOG_N-1:0] stage, stage_n;
    logic [LOG_N-2:0] bf, bf_n;
    logic [CW-1:0]    dcnt, dcnt_n;

    logic             rd_en;
    logic [LOG_N-1:0] gen_a, gen_b;
    logic [LOG_N-2:0] gen_tw;

    logic [PIPE-1:0]  dl_vld;
    logic [LOG_N-1:0] dl_a [PIPE];
    logic [LOG_N-1:0] dl_b [PIPE];

    ntt_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
        .stage   (stage),
        .bf      (bf),
        .mode    (mode),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mode  <= NTT_FWD;
            stage <= '0;
            bf    <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            mode  <= mode_n;
            stage <= stage_n;
            bf    <= bf_n;
            dcnt  <= dcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode;
        stage_n = stage;
        bf_n    = bf;
        dcnt_n  = dcnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ISSUE;
                    mode_n  = bus.inv ? NTT_INV : NTT_FWD;
                    stage_n = '0;
                    bf_n    = '0;
                    dcnt_n  = '0;
                end
            end
            ISSUE: begin
                bf_n = bf + 1'b1;
                if (&bf) begin
                    state_n = DRAIN;
                    dcnt_n  = '0;
                end
            end
            DRAIN: begin
                dcnt_n = dcnt + 1'b1;
                if (dcnt == CW'(PIPE - 1)) begin
                    if (stage == LOG_N'(LOG_N - 1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage + 1'b1;
                        bf_n    = '0;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort beats everything, including a start in the same IDLE cycle.
        if (bus.clear) begin
            state_n = IDLE;
            stage_n = '0;
            bf_n    = '0;
            dcnt_n  = '0;
        end
    end

    assign rd_en = (state == ISSUE);

    // Addresses are gated so the read/write buses sit at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld <= '0;
            for (int i = 0; i < PIPE; i++) begin
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else begin
            dl_vld  <= bus.clear ? '0 : {dl_vld[PIPE-2:0], rd_en};
            dl_a[0] <= rd_en ? gen_a : '0;
            dl_b[0] <= rd_en ? gen_b : '0;
            for (int i = 1; i < PIPE; i++) begin
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign bus.busy      = (state == ISSUE) || (state == DRAIN);
    assign bus.done      = (state == DONE);
    assign bus.stage     = stage;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = rd_en ? gen_a : '0;
    assign bus.rd_addr_b = rd_en ? gen_b : '0;
    assign bus.tw_addr   = rd_en ? gen_tw : '0;
    assign bus.bf_valid  = dl_vld[RD_LATENCY-1];
    assign bus.bf_inv    = dl_vld[RD_LATENCY-1] & (mode == NTT_INV);
    assign bus.wr_en     = dl_vld[PIPE-1];
    assign bus.wr_addr_a = dl_a[PIPE-1];
    assign bus.wr_addr_b = dl_b[PIPE-1];

`ifdef NTT_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [15:0] run_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            run_cnt   <= '0;
        end else begin
            if (state == IDLE && bus.start && !bus.clear) begin
                cycle_cnt <= '0;
            end else if (bus.busy && !(&cycle_cnt)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state == DONE) begin
                run_cnt <= run_cnt + 16'd1;
            end
        end
    end

    assign bus.cycle_cnt = cycle_cnt;
    assign bus.run_cnt   = run_cnt;
`endif

endmodule

// File: tb/tb_ntt_pipe_control.sv
// Directed bench for ntt_pipe_control: N=256 default instance plus a LOG_N=4, RD=2, BF=1 instance.
module tb_ntt_pipe_control;
    import ntt_pkg::*;

    localparam int N         = 256;
    localparam int HALF      = HALF_N;
    localparam int RDL       = 1;
    localparam int PIPE      = 4;
    localparam int STAGE_CYC = HALF + PIPE;
    localparam int BUDGET    = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_pipe_control_if #(.LOG_N(8)) bi ();
    ntt_pipe_control_if #(.LOG_N(4)) si ();

    ntt_pipe_control #(.LOG_N(8), .RD_LATENCY(1), .BF_LATENCY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    ntt_pipe_control #(.LOG_N(4), .RD_LATENCY(2), .BF_LATENCY(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (si)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int done_cyc, err_rd, err_bf, err_wr, err_ctl;
    int wr_per_stage [8];
    int got_a  [8][128];
    int got_b  [8][128];
    int got_tw [8][128];

    // Reference addressing written directly from the h / div / mod definition.
    function automatic void model(input int s, input int bf, input logic iv,
                                  output int a, output int b, output int tw);
        int h;
        h  = iv ? (N >> (s + 1)) : (1 << s);
        a  = (bf / h) * 2 * h + (bf % h);
        b  = a + h;
        tw = iv ? ((bf % h) << s) : ((bf % h) << (7 - s));
        tw = tw % HALF;
    endfunction

    task automatic run_big(input logic iv);
        int k, s, off, ea, eb, et;
        logic exp_bf, exp_wr;
        done_cyc = -1;
        err_rd = 0; err_bf = 0; err_wr = 0; err_ctl = 0;
        for (int i = 0; i < 8; i++) wr_per_stage[i] = 0;
        @(negedge clk);
        bi.start = 1'b1;
        bi.inv   = iv;
        @(negedge clk);
        bi.start = 1'b0;
        bi.inv   = 1'b0;
        k = 1;
        while (k <= BUDGET && done_cyc < 0) begin
            s   = (k - 1) / STAGE_CYC;
            off = (k - 1) % STAGE_CYC;
            if (bi.done === 1'b1) begin
                done_cyc = k;
            end else if (s >= 8) begin
                err_ctl++;
            end else begin
                if (bi.busy !== 1'b1 || bi.stage !== 8'(s)) err_ctl++;
                if (bi.rd_en !== (off < HALF)) err_rd++;
                if (off < HALF) begin
                    model(s, off, iv, ea, eb, et);
                    got_a[s][off]  = int'(bi.rd_addr_a);
                    got_b[s][off]  = int'(bi.rd_addr_b);
                    got_tw[s][off] = int'(bi.tw_addr);
                    if (bi.rd_addr_a !== 8'(ea) || bi.rd_addr_b !== 8'(eb) || bi.tw_addr !== 7'(et))
                        err_rd++;
                end
                exp_bf = (off >= RDL) && (off < HALF + RDL);
                if (bi.bf_valid !== exp_bf || bi.bf_inv !== (exp_bf & iv)) err_bf++;
                exp_wr = (off >= PIPE) && (off < HALF + PIPE);
                if (bi.wr_en !== exp_wr) err_wr++;
                if (exp_wr) begin
                    model(s, off - PIPE, iv, ea, eb, et);
                    if (bi.wr_addr_a !== 8'(ea) || bi.wr_addr_b !== 8'(eb)) err_wr++;
                end
                if (bi.wr_en === 1'b1) wr_per_stage[s]++;
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bi.busy, bi.done, bi.rd_en, bi.bf_valid, bi.wr_en, bi.stage, bi.rd_addr_a, bi.rd_addr_b,
             bi.tw_addr, bi.wr_addr_a, bi.wr_addr_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b rd_en=%b wr_en=%b rd_addr_b=%0d expected all zero",
                     bi.busy, bi.rd_en, bi.wr_en, bi.rd_addr_b);
        end
        rst = 1'b0;
        @(negedge clk);
        bi.start = 1'b1;
        @(negedge clk);
        bi.start = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (bi.rd_en !== 1'b1 || bi.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_issue: got rd_en=%b busy=%b expected 1 1", bi.rd_en, bi.busy);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bi.busy !== 1'b0 || bi.rd_en !== 1'b0 || bi.wr_en !== 1'b0 || bi.stage !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid_issue: got busy=%b rd_en=%b wr_en=%b stage=%0d expected 0 0 0 0",
                     bi.busy, bi.rd_en, bi.wr_en, bi.stage);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bi.busy !== 1'b0 || bi.rd_en !== 1'b0 || bi.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stays_idle: got busy=%b rd_en=%b done=%b expected 0 0 0",
                     bi.busy, bi.rd_en, bi.done);
        end
    endtask

    task automatic check_run(input string tag);
        n_cmp++;
        if (done_cyc !== 1057) begin
            n_bad++;
            $display("FAIL %s_done_cycle: got %0d expected 1057", tag, done_cyc);
        end
        n_cmp++;
        if (err_rd !== 0 || err_bf !== 0 || err_wr !== 0 || err_ctl !== 0) begin
            n_bad++;
            $display("FAIL %s_pipeline: got rd=%0d bf=%0d wr=%0d ctl=%0d bad cycles expected 0",
                     tag, err_rd, err_bf, err_wr, err_ctl);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_per_stage[i] !== 128) begin
                n_bad++;
                $display("FAIL %s_writes_stage%0d: got %0d expected 128", tag, i, wr_per_stage[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bi.done !== 1'b0 || bi.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after_done: got done=%b busy=%b expected 0 0", tag, bi.done, bi.busy);
        end
    endtask

    task automatic test_forward();
        run_big(1'b0);
        check_run("fwd");
        n_cmp++;
        if (got_a[0][0] !== 0 || got_b[0][0] !== 1 || got_tw[0][0] !== 0) begin
            n_bad++;
            $display("FAIL fwd_s0_bf0: got (%0d,%0d) tw %0d expected (0,1) tw 0",
                     got_a[0][0], got_b[0][0], got_tw[0][0]);
        end
        n_cmp++;
        if (got_a[7][5] !== 5 || got_b[7][5] !== 133 || got_tw[7][5] !== 5) begin
            n_bad++;
            $display("FAIL fwd_s7_bf5: got (%0d,%0d) tw %0d expected (5,133) tw 5",
                     got_a[7][5], got_b[7][5], got_tw[7][5]);
        end
    endtask

    task automatic test_inverse();
        run_big(1'b1);
        check_run("inv");
        n_cmp++;
        if (got_a[0][3] !== 3 || got_b[0][3] !== 131 || got_tw[0][3] !== 3) begin
            n_bad++;
            $display("FAIL inv_s0_bf3: got (%0d,%0d) tw %0d expected (3,131) tw 3",
                     got_a[0][3], got_b[0][3], got_tw[0][3]);
        end
        n_cmp++;
        if (got_a[7][3] !== 6 || got_b[7][3] !== 7 || got_tw[7][3] !== 0) begin
            n_bad++;
            $display("FAIL inv_s7_bf3: got (%0d,%0d) tw %0d expected (6,7) tw 0",
                     got_a[7][3], got_b[7][3], got_tw[7][3]);
        end
    endtask

    task automatic test_clear();
        int wr_seen, done_seen;
        @(negedge clk);
        bi.start = 1'b1;
        @(negedge clk);
        bi.start = 1'b0;
        repeat (406) @(negedge clk);
        n_cmp++;
        if (bi.stage !== 8'd3 || bi.rd_en !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_setup: got stage=%0d rd_en=%b expected 3 1", bi.stage, bi.rd_en);
        end
        bi.clear = 1'b1;
        @(negedge clk);
        bi.clear = 1'b0;
        n_cmp++;
        if (bi.busy !== 1'b0 || bi.rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_to_idle: got busy=%b rd_en=%b expected 0 0", bi.busy, bi.rd_en);
        end
        wr_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bi.wr_en === 1'b1) wr_seen++;
            if (bi.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (wr_seen !== 0 || done_seen !== 0) begin
            n_bad++;
            $display("FAIL clear_no_writes: got wr=%0d done=%0d expected 0 0", wr_seen, done_seen);
        end
        bi.start = 1'b1;
        bi.clear = 1'b1;
        @(negedge clk);
        bi.start = 1'b0;
        bi.clear = 1'b0;
        n_cmp++;
        if (bi.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_beats_start: got busy=%b expected 0", bi.busy);
        end
        run_big(1'b0);
        check_run("after_clear");
`ifdef NTT_CTRL_PERF_EN
        n_cmp++;
        if (bi.cycle_cnt !== 32'd1056 || bi.run_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL perf_big: got cycle_cnt=%0d run_cnt=%0d expected 1056 3",
                     bi.cycle_cnt, bi.run_cnt);
        end
`endif
    endtask

    task automatic test_small_params();
        int k, done_k, first_rd, first_bf, first_wr, wr_total;
        done_k = -1; first_rd = -1; first_bf = -1; first_wr = -1; wr_total = 0;
        @(negedge clk);
        si.start = 1'b1;
        @(negedge clk);
        si.start = 1'b0;
        k = 1;
        while (k <= 200 && done_k < 0) begin
            if (si.done === 1'b1) done_k = k;
            if (si.rd_en === 1'b1 && first_rd < 0) first_rd = k;
            if (si.bf_valid === 1'b1 && first_bf < 0) first_bf = k;
            if (si.wr_en === 1'b1 && first_wr < 0) first_wr = k;
            if (si.wr_en === 1'b1) wr_total++;
            if (done_k < 0) begin
                @(negedge clk);
                k++;
            end
        end
        n_cmp++;
        if (done_k !== 45) begin
            n_bad++;
            $display("FAIL small_done_cycle: got %0d expected 45", done_k);
        end
        n_cmp++;
        if (first_rd !== 1 || first_bf !== 3 || first_wr !== 4) begin
            n_bad++;
            $display("FAIL small_latency: got rd=%0d bf=%0d wr=%0d expected 1 3 4",
                     first_rd, first_bf, first_wr);
        end
        n_cmp++;
        if (wr_total !== 32) begin
            n_bad++;
            $display("FAIL small_writes: got %0d expected 32", wr_total);
        end
`ifdef NTT_CTRL_PERF_EN
        n_cmp++;
        if (si.cycle_cnt !== 32'd44 || si.run_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL perf_small: got cycle_cnt=%0d run_cnt=%0d expected 44 1",
                     si.cycle_cnt, si.run_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bi.start = 1'b0; bi.inv = 1'b0; bi.clear = 1'b0;
        si.start = 1'b0; si.inv = 1'b0; si.clear = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_forward();
        test_inverse();
        test_clear();
        test_small_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
